// File: rtl/mpu_sample_sequencer_if.sv
// mpu_sample_sequencer_if: register-read handshake between the sample
// sequencer (master) and the MPU-6050 register wrapper / I2C side (slave).
//
// Handshake: the master raises en with register_selector stable and holds
// both until the slave returns a one-cycle xfer_done pulse with the read byte
// valid on data_in in that same cycle; en then drops for at least one cycle
// before the next byte is requested. xfer_done while en is low is ignored.
interface mpu_sample_sequencer_if;
    logic [3:0] register_selector;
    logic       en;
    logic       xfer_done;
    logic [7:0] data_in;

    modport master (
        output register_selector,
        output en,
        input  xfer_done,
        input  data_in
    );

    modport slave (
        input  register_selector,
        input  en,
        output xfer_done,
        output data_in
    );
endinterface

// File: rtl/mpu_sample_sequencer.sv
// mpu_sample_sequencer: walks the MPU-6050 wrapper through the gyro X/Y/Z and
// temperature H/L registers, captures each byte into a shadow buffer and
// commits all four 16-bit samples together, repeating every SAMPLE_PERIOD
// cycles while run is high.
// Optional build macro MPU_SEQ_WHOAMI_EN: one WHO_AM_I read (selector 4'b0111)
// before the first sweep after reset; a wrong byte or a timeout parks the
// block in ID_FAIL with id_err high until reset.
module mpu_sample_sequencer #(
    parameter int SAMPLE_PERIOD = 100000,
    parameter int DONE_TIMEOUT  = 50000
`ifdef MPU_SEQ_WHOAMI_EN
    , parameter logic [7:0] WHOAMI_VALUE = 8'h68
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    mpu_sample_sequencer_if.master        bus,
    output logic [15:0]                   gyro_x,
    output logic [15:0]                   gyro_y,
    output logic [15:0]                   gyro_z,
    output logic [15:0]                   temp,
    output logic                          sample_valid,
    output logic                          busy,
    output logic                          timeout_err,
`ifdef MPU_SEQ_WHOAMI_EN
    output logic                          id_err,
`endif
    output logic [2:0]                    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_COMMIT,
        S_PERIOD
`ifdef MPU_SEQ_WHOAMI_EN
        , S_ID_FAIL
`endif
    } state_t;

    localparam int TW = $clog2(DONE_TIMEOUT) + 1;
    localparam int PW = $clog2(SAMPLE_PERIOD) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(DONE_TIMEOUT - 1);
    localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_PERIOD - 1);

    state_t            state_q;
    logic [2:0]        idx_q;
    logic [TW-1:0]     tcnt_q;
    logic [PW-1:0]     pcnt_q;
    logic [7:0][7:0]   shadow_q;
    logic [3:0]        sel_q;
    logic              en_q;
    logic [15:0]       gx_q, gy_q, gz_q, tmp_q;
    logic              sv_q;
    logic              busy_q;
    logic              terr_q;
`ifdef MPU_SEQ_WHOAMI_EN
    logic              id_rd_q;   // current transfer is the WHO_AM_I read
    logic              id_ok_q;   // ID already confirmed since reset
    logic              id_err_q;
`endif

    // Sequencer FSM; every output is a register updated on the transition
    // into the state that owns it, so outputs line up with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            tcnt_q   <= '0;
            pcnt_q   <= '0;
            shadow_q <= '0;
            sel_q    <= '0;
            en_q     <= 1'b0;
            gx_q     <= '0;
            gy_q     <= '0;
            gz_q     <= '0;
            tmp_q    <= '0;
            sv_q     <= 1'b0;
            busy_q   <= 1'b0;
            terr_q   <= 1'b0;
`ifdef MPU_SEQ_WHOAMI_EN
            id_rd_q  <= 1'b0;
            id_ok_q  <= 1'b0;
            id_err_q <= 1'b0;
`endif
        end else begin
            sv_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q <= S_ISSUE;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        en_q    <= 1'b1;
`ifdef MPU_SEQ_WHOAMI_EN
                        if (!id_ok_q) begin
                            id_rd_q <= 1'b1;
                            sel_q   <= 4'b0111;
                        end else begin
                            sel_q   <= 4'b1000;
                        end
`else
                        sel_q   <= 4'b1000;
`endif
                    end
                end
                S_ISSUE: begin
                    tcnt_q  <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.xfer_done) begin
                        // done wins over a timeout reached in the same cycle
                        en_q    <= 1'b0;
                        state_q <= S_GAP;
`ifdef MPU_SEQ_WHOAMI_EN
                        if (id_rd_q) begin
                            if (bus.data_in == WHOAMI_VALUE) begin
                                id_ok_q  <= 1'b1;
                            end else begin
                                state_q  <= S_ID_FAIL;
                                id_err_q <= 1'b1;
                                sel_q    <= '0;
                            end
                        end else
`endif
                        shadow_q[idx_q] <= bus.data_in;
                    end else if (tcnt_q == T_LAST) begin
                        // abandon the sweep; shadow bytes never reach outputs
                        en_q    <= 1'b0;
                        sel_q   <= '0;
                        terr_q  <= 1'b1;
                        pcnt_q  <= '0;
                        state_q <= S_PERIOD;
`ifdef MPU_SEQ_WHOAMI_EN
                        if (id_rd_q) begin
                            state_q  <= S_ID_FAIL;
                            id_err_q <= 1'b1;
                        end
`endif
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                S_GAP: begin
`ifdef MPU_SEQ_WHOAMI_EN
                    if (id_rd_q) begin
                        id_rd_q <= 1'b0;
                        idx_q   <= '0;
                        sel_q   <= 4'b1000;
                        en_q    <= 1'b1;
                        state_q <= S_ISSUE;
                    end else
`endif
                    if (idx_q != 3'd7) begin
                        idx_q   <= idx_q + 3'd1;
                        sel_q   <= {1'b1, idx_q + 3'd1};
                        en_q    <= 1'b1;
                        state_q <= S_ISSUE;
                    end else begin
                        gx_q    <= {shadow_q[0], shadow_q[1]};
                        gy_q    <= {shadow_q[2], shadow_q[3]};
                        gz_q    <= {shadow_q[4], shadow_q[5]};
                        tmp_q   <= {shadow_q[6], shadow_q[7]};
                        sv_q    <= 1'b1;
                        sel_q   <= '0;
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    pcnt_q  <= '0;
                    state_q <= S_PERIOD;
                end
                S_PERIOD: begin
                    if (pcnt_q == P_LAST) begin
                        if (run) begin
                            idx_q   <= '0;
                            sel_q   <= 4'b1000;
                            en_q    <= 1'b1;
                            state_q <= S_ISSUE;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        pcnt_q <= pcnt_q + PW'(1);
                    end
                end
`ifdef MPU_SEQ_WHOAMI_EN
                S_ID_FAIL: begin
                    en_q <= 1'b0;
                end
`endif
                default: begin
                    en_q    <= 1'b0;
                    sel_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.register_selector = sel_q;
    assign bus.en                = en_q;
    assign gyro_x                = gx_q;
    assign gyro_y                = gy_q;
    assign gyro_z                = gz_q;
    assign temp                  = tmp_q;
    assign sample_valid          = sv_q;
    assign busy                  = busy_q;
    assign timeout_err           = terr_q;
`ifdef MPU_SEQ_WHOAMI_EN
    assign id_err                = id_err_q;
`endif
    assign dbg_state             = state_q;

endmodule

// File: tb/tb_mpu_sample_sequencer.sv
// tb_mpu_sample_sequencer: directed bench for mpu_sample_sequencer with a
// behavioural slave that answers each en rise after RESP_DLY cycles.
module tb_mpu_sample_sequencer;

    localparam int RESP_DLY = 5;
`ifdef MPU_SEQ_WHOAMI_EN
    localparam int ID_OFS = 8;   // ISSUE + 6 WAIT + GAP of the ID read
`else
    localparam int ID_OFS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b1;
    logic [15:0] gyro_x, gyro_y, gyro_z, temp;
    logic        sample_valid, busy, timeout_err;
    logic [2:0]  dbg_state;
`ifdef MPU_SEQ_WHOAMI_EN
    logic        id_err;
`endif

    mpu_sample_sequencer_if ifc ();

    mpu_sample_sequencer #(
        .SAMPLE_PERIOD (20),
        .DONE_TIMEOUT  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .bus          (ifc),
        .gyro_x       (gyro_x),
        .gyro_y       (gyro_y),
        .gyro_z       (gyro_z),
        .temp         (temp),
        .sample_valid (sample_valid),
        .busy         (busy),
        .timeout_err  (timeout_err),
`ifdef MPU_SEQ_WHOAMI_EN
        .id_err       (id_err),
`endif
        .dbg_state    (dbg_state)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // slave stimulus controls
    logic [7:0] tbl [8];
    logic [7:0] id_byte = 8'h68;
    int         silent_sel = 99;
    logic       force_done = 1'b0;

    // slave: sees the en rise just after the edge, pulses xfer_done
    // RESP_DLY cycles later, data taken from tbl by selector
    initial begin : slave
        int         cd;
        logic [3:0] cur_sel;
        logic       s_en_prev;
        cd = 0;
        cur_sel = '0;
        s_en_prev = 1'b0;
        ifc.xfer_done = 1'b0;
        ifc.data_in = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                cd = 0;
                s_en_prev = 1'b0;
                ifc.xfer_done = 1'b0;
            end else begin
                if (ifc.en && !s_en_prev) begin
                    cd = RESP_DLY + 2;
                    cur_sel = ifc.register_selector;
                end else if (cd > 0) begin
                    cd--;
                end
                s_en_prev = ifc.en;
                ifc.data_in = cur_sel[3] ? tbl[cur_sel[2:0]] : id_byte;
                ifc.xfer_done = ((cd == 1) && ((int'(cur_sel) - 8) != silent_sel)) || force_done;
            end
        end
    end

    // monitor: logs every en rise (selector, cycle, preceding low run) and
    // every sample_valid cycle
    logic [3:0] sel_log [$];
    int         rise_cyc [$];
    int         low_log [$];
    int         sv_cyc [$];
    int         id_rises = 0;
    int         low_run = 0;
    logic       mon_en_prev = 1'b0;

    always @(negedge clk) begin
        if (ifc.en && !mon_en_prev) begin
            if (ifc.register_selector[3]) begin
                sel_log.push_back(ifc.register_selector);
                rise_cyc.push_back(cyc);
                low_log.push_back(low_run);
            end else begin
                id_rises++;
            end
        end
        low_run = ifc.en ? 0 : low_run + 1;
        if (sample_valid) sv_cyc.push_back(cyc);
        mon_en_prev = ifc.en;
    end

    // scoreboard counters and helpers
    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_tbl(input logic [7:0] base, input logic [7:0] stride);
        for (int i = 0; i < 8; i++) tbl[i] = 8'(base + stride * 8'(i));
    endtask

    task automatic clear_logs();
        sel_log.delete();
        rise_cyc.delete();
        low_log.delete();
        sv_cyc.delete();
        id_rises = 0;
    endtask

    task automatic wait_sv(input int n, input string tag);
        int k = 0;
        while (sv_cyc.size() < n && k < 400) begin
            step();
            k++;
        end
        check(tag, 32'(sv_cyc.size()), 32'(n));
    endtask

    task automatic wait_rises(input int n, input string tag);
        int k = 0;
        while (sel_log.size() < n && k < 400) begin
            step();
            k++;
        end
        check(tag, 32'(sel_log.size()), 32'(n));
    endtask

    task automatic check_samples(input string tag, input logic [15:0] x, input logic [15:0] y,
                                 input logic [15:0] z, input logic [15:0] t);
        check({tag, "_gx"}, 32'(gyro_x), 32'(x));
        check({tag, "_gy"}, 32'(gyro_y), 32'(y));
        check({tag, "_gz"}, 32'(gyro_z), 32'(z));
        check({tag, "_tmp"}, 32'(temp), 32'(t));
    endtask

    initial begin : main
        int k;
        int t_ev;
        int rel_cyc;
        int en_hi;
        set_tbl(8'h11, 8'h11);

`ifdef MPU_SEQ_WHOAMI_EN
        // WHO_AM_I answered correctly: one ID read, then sweep 0
        repeat (3) step();
        check("id_err_reset", 32'(id_err), 32'd0);
        id_byte = 8'h68;
        rst = 1'b1;
        wait_rises(1, "id_ok_first_sweep");
        check("id_read_count", 32'(id_rises), 32'd1);
        check("id_first_sel", 32'(sel_log[0]), 32'h8);
        check("id_err_after_match", 32'(id_err), 32'd0);
        // WHO_AM_I answered with 8'h72: terminal ID_FAIL
        rst = 1'b0;
        step();
        clear_logs();
        id_byte = 8'h72;
        rst = 1'b1;
        k = 0;
        while (!id_err && k < 100) begin
            step();
            k++;
        end
        check("id_err_mismatch", 32'(id_err), 32'd1);
        check("id_fail_busy", 32'(busy), 32'd1);
        en_hi = 0;
        repeat (1000) begin
            step();
            if (ifc.en) en_hi++;
        end
        check("id_fail_en_low", 32'(en_hi), 32'd0);
        check("id_fail_no_sweep", 32'(sel_log.size()), 32'd0);
        rst = 1'b0;
        id_byte = 8'h68;
`endif

        // reset state with run high
        repeat (3) step();
        check("rst_sel", 32'(ifc.register_selector), 32'd0);
        check("rst_en", 32'(ifc.en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sv", 32'(sample_valid), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check_samples("rst", 16'h0, 16'h0, 16'h0, 16'h0);
        clear_logs();
        rst = 1'b1;

        // sweep 0: bytes 11..88, selector 8..F, 64 cycles, 1-cycle en gaps
        wait_sv(1, "sweep0_done");
        for (int i = 0; i < 8; i++) check($sformatf("sweep0_sel%0d", i), 32'(sel_log[i]), 32'(8 + i));
        for (int i = 1; i < 8; i++) check($sformatf("sweep0_gap%0d", i), 32'(low_log[i]), 32'd1);
        check_samples("sweep0", 16'h1122, 16'h3344, 16'h5566, 16'h7788);
        check("sweep0_latency", 32'(sv_cyc[0] - rise_cyc[0]), 32'd64);
        step();
        check("sweep0_sv_pulse", 32'(sample_valid), 32'd0);
        check("sweep0_sv_count", 32'(sv_cyc.size()), 32'd1);
        check("period_busy", 32'(busy), 32'd1);
        check("period_en", 32'(ifc.en), 32'd0);
        check("period_sel", 32'(ifc.register_selector), 32'd0);

        // stray xfer_done during PERIOD must not disturb anything
        set_tbl(8'hA0, 8'h01);
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        step();
        step();
        check_samples("stray_done", 16'h1122, 16'h3344, 16'h5566, 16'h7788);

        // sweep 1: ISSUE after COMMIT cycle + 20 PERIOD cycles
        wait_sv(2, "sweep1_done");
        check("period_length", 32'(rise_cyc[8] - sv_cyc[0]), 32'd21);
        check("sweep1_sel0", 32'(sel_log[8]), 32'h8);
        check("sweep1_latency", 32'(sv_cyc[1] - rise_cyc[8]), 32'd64);
        check_samples("sweep1", 16'hA0A1, 16'hA2A3, 16'hA4A5, 16'hA6A7);

        // sweep 2: slave silent on byte 3 -> timeout after 16 WAIT cycles
        silent_sel = 3;
        set_tbl(8'hB0, 8'h01);
        k = 0;
        while (!timeout_err && k < 200) begin
            step();
            k++;
        end
        t_ev = cyc;
        check("timeout_set", 32'(timeout_err), 32'd1);
        check("timeout_cycle", 32'(t_ev - rise_cyc[19]), 32'd17);
        check_samples("timeout_hold", 16'hA0A1, 16'hA2A3, 16'hA4A5, 16'hA6A7);
        check("timeout_no_sv", 32'(sv_cyc.size()), 32'd2);
        check("timeout_en", 32'(ifc.en), 32'd0);
        check("timeout_sel", 32'(ifc.register_selector), 32'd0);
        silent_sel = 99;
        wait_rises(21, "after_timeout_rise");
        check("after_timeout_sel", 32'(sel_log[20]), 32'h8);
        check("after_timeout_period", 32'(rise_cyc[20] - t_ev), 32'd20);
        check("timeout_sticky", 32'(timeout_err), 32'd1);

        // sweep 3 commits B0..B7; then run dropped during byte 2 of sweep 4
        wait_sv(3, "sweep3_done");
        check_samples("sweep3", 16'hB0B1, 16'hB2B3, 16'hB4B5, 16'hB6B7);
        set_tbl(8'hC0, 8'h01);
        wait_rises(31, "sweep4_byte2");
        run = 1'b0;
        wait_sv(4, "sweep4_done");
        check_samples("sweep4", 16'hC0C1, 16'hC2C3, 16'hC4C5, 16'hC6C7);
        check("sweep4_latency", 32'(sv_cyc[3] - rise_cyc[28]), 32'd64);
        k = 0;
        while (busy && k < 100) begin
            step();
            k++;
        end
        check("idle_after_period", 32'(cyc - sv_cyc[3]), 32'd21);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_sel", 32'(ifc.register_selector), 32'd0);
        check("idle_en", 32'(ifc.en), 32'd0);
        repeat (30) step();
        check("idle_no_sweep", 32'(sel_log.size()), 32'd36);

        // asynchronous reset while waiting on byte 5
        run = 1'b1;
        set_tbl(8'hD0, 8'h01);
        wait_rises(42, "sweep5_byte5");
        step();
        step();
        rst = 1'b0;
        #1;
        check("arst_sel", 32'(ifc.register_selector), 32'd0);
        check("arst_en", 32'(ifc.en), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_terr", 32'(timeout_err), 32'd0);
        check("arst_sv", 32'(sample_valid), 32'd0);
        check("arst_state", 32'(dbg_state), 32'd0);
        check_samples("arst", 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        step();
        rst = 1'b1;
        rel_cyc = cyc;
        wait_rises(43, "restart_rise");
        check("restart_sel", 32'(sel_log[42]), 32'h8);
        check("restart_delay", 32'(rise_cyc[42] - rel_cyc), 32'(1 + ID_OFS));
        wait_sv(5, "restart_done");
        check_samples("restart", 16'hD0D1, 16'hD2D3, 16'hD4D5, 16'hD6D7);
        check("restart_terr", 32'(timeout_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
